byte_serializer_ctrl: RTL
=========================

// Module: byte_serializer_ctrl
// PURPOSE
//  Sequencer for the PHY 32/16/8-to-8 width converter. Accepts one word per
//  valid/ready handshake with a width code. Emits its 1, 2 or 4 bytes, one per
//  clk, under downstream backpressure, and drives the byte-select for the lane
//  mux. Sits between the link-layer word source and the 8-bit symbol path.
// PARAMETERS
//  MSB_FIRST  0  0: byte 0 (bits 7:0) sent first; 1: highest valid byte first
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  reset      in   1   asynchronous, active-high; clears all state
//  in_data    in   32  input word; 16-bit mode uses [15:0], 8-bit uses [7:0]
//  in_mode    in   2   00=8-bit, 01=16-bit, 10=32-bit, 11=illegal
//  in_valid   in   1   source has a word
//  in_ready   out  1   block can take a word this cycle (combinational)
//  out_data   out  8   current byte (registered)
//  out_valid  out  1   out_data valid (registered)
//  out_ready  in   1   sink accepts out_data this cycle
//  out_sel    out  2   index of byte on out_data (registered, to converter mux)
//  out_last   out  1   out_data is final byte of its word
//  mode_err   out  1   1-cycle pulse: illegal in_mode word was dropped
// BEHAVIOUR
//  Reset (async): state=IDLE; out_data=0, out_valid=0, out_sel=0, out_last=0,
//   mode_err=0; held word and byte counter cleared; in_ready=0 while reset=1.
//  States: IDLE, SEND. nbytes = 1/2/4 for mode 00/01/10.
//  in_ready = IDLE | (SEND & out_valid & out_ready & out_last).
//  Accept (in_valid & in_ready at posedge), mode legal:
//   - latch word and nbytes; cnt=0; state=SEND.
//   - out_valid=1 on the next cycle. Latency is 1 clk from accept to first byte.
//  Byte k of a word (k=0..nbytes-1):
//   - index = k if MSB_FIRST=0, else nbytes-1-k.
//   - out_sel=index; out_data=word[8*index+7 -: 8]; out_last=(k==nbytes-1).
//  SEND, out_ready=0: out_data/out_sel/out_last/out_valid hold, no advance.
//  SEND, out_ready=1, not last: cnt+1, next byte presented on the next cycle.
//  SEND, out_ready=1, last:
//   - If in_valid=1 (legal mode), accept back-to-back: the new word's first
//     byte follows with no bubble.
//   - Otherwise go to IDLE; out_valid=0, out_last=0. out_data/out_sel hold.
//  Illegal mode 11 accepted:
//   - word discarded; mode_err=1 for exactly one cycle; no bytes emitted.
//   - if it arrives during the last-byte handoff, go to IDLE after that byte.
//  8-bit mode: single byte, out_last=1 on it, out_sel=0.
//  in_data/in_mode are ignored when in_ready=0; the held word never changes
//   mid-word.
//  Reset mid-word: partial word is lost; no remaining bytes are emitted.
//  Sustained throughput: 1 byte/clk when out_ready=1 and the source keeps up.
// TESTING
//  T1 32-bit: in=0xA1B2C3D4 mode=10, MSB_FIRST=0, out_ready=1 ->
//     bytes D4,C3,B2,A1; out_sel 0,1,2,3; out_last only on A1.
//  T2 back-to-back: 16-bit 0x1234, then 8-bit 0x56 held valid ->
//     34,12,56 on 3 consecutive clks, no bubble; in_ready high on 12's cycle.
//  T3 backpressure: 32-bit 0xDEADBEEF, out_ready low 3 clks after first byte ->
//     EF held stable 4 clks; sequence EF,BE,AD,DE intact.
//  T4 MSB_FIRST=1, 16-bit 0xCAFE -> FE is ignored?no: CA(sel 1), FE(sel 0);
//     bits [31:16] of in_data ignored.
//  T5 mode=11 with 0x11223344 -> no out_valid; mode_err one clk; next legal
//     word accepted on the following clk.
//  T6 assert reset after 2nd byte of a 32-bit word ->
//     all outputs 0 immediately (async); after release, IDLE, in_ready=1.

Source files
------------

// File: rtl/byte_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// byte_serializer_ctrl
//
// Sequencer for the PHY 32/16/8-to-8 width converter. The block takes one word
// per valid/ready handshake, together with a width code. It then emits the 1, 2
// or 4 bytes of that word, one byte per clock, and waits whenever the sink
// applies backpressure. It also drives the byte-select that steers the
// converter lane mux.
//
// Parameters
//   MSB_FIRST  0: byte 0 (bits 7:0) is sent first
//              1: the highest valid byte is sent first
//
// Ports
//   clk        in   1   single clock; all logic runs on posedge
//   reset      in   1   asynchronous, active-high; clears all state
//   in_data    in   32  input word; 16-bit mode uses [15:0], 8-bit uses [7:0]
//   in_mode    in   2   00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
//   in_valid   in   1   the source has a word
//   in_ready   out  1   a word can be taken this cycle (combinational)
//   out_data   out  8   current byte (registered)
//   out_valid  out  1   out_data is valid (registered)
//   out_ready  in   1   the sink accepts out_data this cycle
//   out_sel    out  2   index of the byte on out_data (registered)
//   out_last   out  1   out_data is the final byte of its word (registered)
//   mode_err   out  1   one-cycle pulse: a word with an illegal mode was dropped
// -----------------------------------------------------------------------------
module byte_serializer_ctrl #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_mode,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_sel,
    output logic        out_last,
    output logic        mode_err
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t      state, state_next;
    logic [31:0] word, word_next;
    logic [1:0]  last_idx, last_idx_next;   // nbytes - 1 of the held word
    logic [1:0]  cnt, cnt_next;             // byte position k within the word
    logic [7:0]  data_next;
    logic [1:0]  sel_next;
    logic        valid_next, last_next, err_next;

    logic        accept;
    logic        mode_legal;
    logic [1:0]  in_last_idx;
    logic        load;
    logic [1:0]  cnt_inc;
    logic [1:0]  idx;

    // The k-th byte sent maps onto a lane index that depends on the send order.
    function automatic logic [1:0] byte_index(input logic [1:0] k, input logic [1:0] lst);
        return MSB_FIRST ? 2'(lst - k) : k;
    endfunction

    assign mode_legal = (in_mode != 2'b11);
    assign cnt_inc    = 2'(cnt + 2'd1);

    always_comb begin
        case (in_mode)
            2'b01:   in_last_idx = 2'd1;
            2'b10:   in_last_idx = 2'd3;
            default: in_last_idx = 2'd0;
        endcase
    end

    // State register and registered datapath
    // NOTE: sequential state uses non-blocking assignments only. Every register
    // here, including the held word, is cleared by reset, so a partial word
    // cannot leak out after reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            word      <= '0;
            last_idx  <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            mode_err  <= 1'b0;
        end else begin
            state     <= state_next;
            word      <= word_next;
            last_idx  <= last_idx_next;
            cnt       <= cnt_next;
            out_data  <= data_next;
            out_valid <= valid_next;
            out_sel   <= sel_next;
            out_last  <= last_next;
            mode_err  <= err_next;
        end
    end

    // Next-state logic
    // NOTE: every signal this block drives first gets a hold or idle default,
    // so no branch can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        word_next     = word;
        last_idx_next = last_idx;
        cnt_next      = cnt;
        valid_next    = out_valid;
        data_next     = out_data;
        sel_next      = out_sel;
        last_next     = out_last;
        err_next      = 1'b0;
        load          = 1'b0;
        idx           = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    if (mode_legal) load = 1'b1;
                    else            err_next = 1'b1;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (!out_last) begin
                        idx       = byte_index(cnt_inc, last_idx);
                        cnt_next  = cnt_inc;
                        sel_next  = idx;
                        data_next = word[{idx, 3'b000} +: 8];
                        last_next = (cnt_inc == last_idx);
                    end else if (accept && mode_legal) begin
                        // Back-to-back hand-off: the new word's first byte is
                        // sent without a bubble.
                        load = 1'b1;
                    end else begin
                        // out_data and out_sel keep their last values.
                        state_next = IDLE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                        err_next   = accept;   // accept here implies an illegal mode
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            idx           = byte_index(2'd0, in_last_idx);
            state_next    = SEND;
            word_next     = in_data;
            last_idx_next = in_last_idx;
            cnt_next      = '0;
            valid_next    = 1'b1;
            sel_next      = idx;
            data_next     = in_data[{idx, 3'b000} +: 8];
            last_next     = (in_last_idx == 2'd0);
        end
    end

    // Output logic: in_ready is combinational, so a word can be accepted in the
    // same cycle that the last byte of the previous word is taken.
    always_comb begin
        in_ready = !reset && ((state == IDLE) ||
                   ((state == SEND) && out_valid && out_ready && out_last));
        accept   = in_valid && in_ready;
    end

endmodule
